pwm_duty_decoder: RTL



---
 rtl/pwm_duty_decoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures period/high time between rises and emits a duty code.
// Define PWM_DEC_AVG_EN to report the mean of the last four quotients.
module pwm_duty_decoder #(
    parameter int CNT_W       = 16,
    parameter int OUT_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [OUT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             ovr
);

    localparam int STW = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] DUTY_MAX = '1;
    localparam logic [STW-1:0] LAST_STEP = STW'(OUT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_DIV
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic [CNT_W-1:0]       r_div;
    logic [CNT_W:0]         r_rem;
    logic [OUT_W-1:0]       r_quot;
    logic [STW-1:0]         r_step;
    logic [OUT_W-1:0]       r_duty;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_stuck;
    logic                   r_ovr;

    logic                   w_pwm_s;
    logic                   w_rise;
    logic                   w_timeout;
    logic [CNT_W-1:0]       w_pcnt_inc;
    logic [CNT_W-1:0]       w_hcnt_inc;
    logic                   w_qbit;
    logic [CNT_W-1:0]       w_trial;
    logic [CNT_W:0]         w_rem_nx;
    logic [OUT_W:0]         w_quot;
    logic [OUT_W-1:0]       w_qsat;
    logic [OUT_W-1:0]       w_duty_new;
    logic [OUT_W-1:0]       w_to_duty;
    logic                   w_div_done;
    logic                   w_to_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_pwm_s    = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_pwm_s & ~r_pwm_d;
    assign w_timeout  = (r_pcnt == CNT_MAX) && !w_rise;
    assign w_pcnt_inc = (r_pcnt == CNT_MAX) ? r_pcnt : r_pcnt + 1'b1;
    assign w_hcnt_inc = (w_pwm_s && r_hcnt != CNT_MAX) ? r_hcnt + 1'b1 : r_hcnt;

    // Remainder stays below 2*divisor, so the low bits of the difference are exact
    assign w_qbit   = (r_rem >= {1'b0, r_div});
    assign w_trial  = r_rem[CNT_W-1:0] - r_div;
    assign w_rem_nx = w_qbit ? {w_trial, 1'b0} : {r_rem[CNT_W-1:0], 1'b0};
    assign w_quot   = {r_quot, w_qbit};
    assign w_qsat   = w_quot[OUT_W] ? DUTY_MAX : w_quot[OUT_W-1:0];

    assign w_to_duty  = w_pwm_s ? DUTY_MAX : '0;
    assign w_div_done = (r_state == S_DIV) && !w_rise && (r_step == LAST_STEP);
    assign w_to_fire  = ((r_state == S_ARM) || (r_state == S_MEAS)) && w_timeout;

`ifdef PWM_DEC_AVG_EN
    logic [OUT_W-1:0] r_h0;
    logic [OUT_W-1:0] r_h1;
    logic [OUT_W-1:0] r_h2;
    logic [OUT_W+1:0] w_sum;

    assign w_sum = (OUT_W+2)'(w_qsat) + (OUT_W+2)'(r_h0)
                 + (OUT_W+2)'(r_h1) + (OUT_W+2)'(r_h2);
    assign w_duty_new = OUT_W'(w_sum >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_h2 <= '0;
        end else if (!enable) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_h2 <= '0;
        end else if (enable && w_to_fire) begin
            r_h0 <= w_to_duty;
            r_h1 <= w_to_duty;
            r_h2 <= w_to_duty;
        end else if (w_div_done) begin
            r_h0 <= w_qsat;
            r_h1 <= r_h0;
            r_h2 <= r_h1;
        end
    end
`else
    assign w_duty_new = w_qsat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_step   <= '0;
            r_duty   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            if (!enable) begin
                r_state <= S_IDLE;
                r_pcnt  <= '0;
                r_hcnt  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: r_state <= S_ARM;
                    S_ARM, S_MEAS: begin
                        if (w_rise) begin
                            if (r_state == S_MEAS) begin
                                r_div  <= r_pcnt;
                                r_rem  <= {1'b0, r_hcnt};
                                r_quot <= '0;
                                r_step <= '0;
                            end
                            r_pcnt  <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                            r_state <= (r_state == S_MEAS) ? S_DIV : S_MEAS;
                        end else if (w_timeout) begin
                            r_stuck  <= 1'b1;
                            r_duty   <= w_to_duty;
                            r_period <= '0;
                            r_valid  <= 1'b1;
                            r_pcnt   <= '0;
                            r_hcnt   <= '0;
                            r_state  <= S_ARM;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                            if (r_state == S_MEAS) r_hcnt <= w_hcnt_inc;
                        end
                    end
                    S_DIV: begin
                        if (w_rise) begin
                            // Period too short to finish the divide: drop it
                            r_ovr   <= 1'b1;
                            r_pcnt  <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                            r_state <= S_MEAS;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                            r_hcnt <= w_hcnt_inc;
                            r_rem  <= w_rem_nx;
                            r_quot <= w_quot[OUT_W-1:0];
                            r_step <= r_step + 1'b1;
                            if (w_div_done) begin
                                r_duty   <= w_duty_new;
                                r_period <= r_div;
                                r_valid  <= 1'b1;
                                r_stuck  <= 1'b0;
                                r_state  <= S_MEAS;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign duty   = r_duty;
    assign period = r_period;
    assign valid  = r_valid;
    assign stuck  = r_stuck;
    assign ovr    = r_ovr;

endmodule
